// File: rtl/apb_gpio_pkg.sv
// -----------------------------------------------------------------------------
// apb_gpio_pkg
// Shared definitions for the APB GPIO block with edge interrupts:
//   - ADDR_W           : APB byte-address width
//   - OFF_*            : register byte offsets
//   - reg_sel_e        : register select decoded from PADDR[4:2]
//   - addr_to_sel()    : byte address -> register select
//   - sel_is_mapped()  : 1 when the select hits an implemented register
// -----------------------------------------------------------------------------
package apb_gpio_pkg;

    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] OFF_MODE    = 5'h00;
    localparam logic [ADDR_W-1:0] OFF_ODR     = 5'h04;
    localparam logic [ADDR_W-1:0] OFF_IDR     = 5'h08;
    localparam logic [ADDR_W-1:0] OFF_RISE_EN = 5'h0C;
    localparam logic [ADDR_W-1:0] OFF_FALL_EN = 5'h10;
    localparam logic [ADDR_W-1:0] OFF_ISR     = 5'h14;

    // Word index of each register; codes 6 and 7 are unmapped.
    typedef enum logic [2:0] {
        SEL_MODE    = OFF_MODE[4:2],
        SEL_ODR     = OFF_ODR[4:2],
        SEL_IDR     = OFF_IDR[4:2],
        SEL_RISE_EN = OFF_RISE_EN[4:2],
        SEL_FALL_EN = OFF_FALL_EN[4:2],
        SEL_ISR     = OFF_ISR[4:2],
        SEL_RSVD6   = 3'd6,
        SEL_RSVD7   = 3'd7
    } reg_sel_e;

    function automatic reg_sel_e addr_to_sel(input logic [ADDR_W-1:0] addr);
        return reg_sel_e'(addr[4:2]);
    endfunction

    function automatic logic sel_is_mapped(input reg_sel_e sel);
        return (sel != SEL_RSVD6) && (sel != SEL_RSVD7);
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// -----------------------------------------------------------------------------
// gpio_sync_edge
// Per-pin metastability synchronizer followed by a previous-value flop, with
// combinational rise/fall detection between the synchronized and previous
// values.
// Ports:
//   PCLK      in   clock
//   PRESET    in   asynchronous active-high reset (clears all flops)
//   gpio_in   in   WIDTH  asynchronous pad inputs
//   sync_val  out  WIDTH  synchronized pin values (last chain stage)
//   rise      out  WIDTH  1 where sync_val = 1 and previous value = 0
//   fall      out  WIDTH  1 where sync_val = 0 and previous value = 1
// -----------------------------------------------------------------------------
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] sync_val,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] prev_p;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_p[s] <= '0;
            end
            prev_p <= '0;
        end else begin
            // stage 0: first capture of the asynchronous pad value
            sync_p[0] <= gpio_in;
            // stages 1..SYNC_STAGES-1: resolution chain
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_p[s] <= sync_p[s-1];
            end
            // previous-value stage for edge detection
            prev_p <= sync_p[SYNC_STAGES-1];
        end
    end

    assign sync_val = sync_p[SYNC_STAGES-1];
    assign rise     = sync_val & ~prev_p;
    assign fall     = ~sync_val & prev_p;

endmodule

// File: rtl/apb_gpio_irq.sv
// -----------------------------------------------------------------------------
// apb_gpio_irq
// APB slave GPIO block: per-pin direction and output data, synchronized input
// read-back, and rising/falling edge interrupts collected in a W1C status
// register that drives a level interrupt.
// Ports:
//   PCLK, PRESET          clock, asynchronous active-high reset
//   PADDR[4:0]            byte address, [4:2] select the register
//   PWDATA[31:0]          write data (low WIDTH bits used)
//   PWRITE, PSEL, PENABLE APB control
//   PRDATA[31:0]          registered read data
//   PREADY                registered; high for one cycle after each access
//   PSLVERR               high with PREADY for unmapped addresses
//   gpio_in[WIDTH-1:0]    asynchronous pad inputs
//   gpio_out[WIDTH-1:0]   pad output data (ODR)
//   gpio_oe[WIDTH-1:0]    pad output enable (MODE), 1 = drive
//   irq                   OR of pending ISR bits
// Registers: 0x00 MODE, 0x04 ODR, 0x08 IDR (RO), 0x0C RISE_EN, 0x10 FALL_EN,
//            0x14 ISR (W1C). 0x18/0x1C respond with PSLVERR.
// -----------------------------------------------------------------------------
module apb_gpio_irq
    import apb_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    input  logic              PWRITE,
    input  logic              PSEL,
    input  logic              PENABLE,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    // Register file
    logic [WIDTH-1:0] mode_q;
    logic [WIDTH-1:0] odr_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] isr_q;

    // Pin path
    logic [WIDTH-1:0] pin_sync;
    logic [WIDTH-1:0] pin_rise;
    logic [WIDTH-1:0] pin_fall;
    logic [WIDTH-1:0] idr_val;

    // Access decode
    reg_sel_e         sel;
    logic             mapped;
    logic             first_acc;
    logic             wr_commit;
    logic             rd_load;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] isr_set;
    logic [WIDTH-1:0] isr_clr;

    // Upper write-data bits and the byte-lane address bits carry no meaning.
    logic unused_bits;
    assign unused_bits = ^{PWDATA, PADDR[1:0]};

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .gpio_in  (gpio_in),
        .sync_val (pin_sync),
        .rise     (pin_rise),
        .fall     (pin_fall)
    );

    // PREADY doubles as the APB state: IDLE/SETUP while PSEL&PENABLE is not
    // yet seen, ACCESS on the single cycle where the transfer is "first",
    // DONE while PREADY is high. Keying on ~PREADY keeps a held PENABLE from
    // committing the same write twice.
    assign first_acc = PSEL & PENABLE & ~PREADY;
    assign sel       = addr_to_sel(PADDR);
    assign mapped    = sel_is_mapped(sel);
    assign wr_commit = first_acc & PWRITE & mapped;
    assign rd_load   = first_acc & (~PWRITE | ~mapped);
    assign wdata     = PWDATA[WIDTH-1:0];

    // Output-mode pins read back the driven value, input-mode pins the pad.
    assign idr_val = (odr_q & mode_q) | (pin_sync & ~mode_q);

    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_MODE:    rd_val = mode_q;
            SEL_ODR:     rd_val = odr_q;
            SEL_IDR:     rd_val = idr_val;
            SEL_RISE_EN: rd_val = rise_en_q;
            SEL_FALL_EN: rd_val = fall_en_q;
            SEL_ISR:     rd_val = isr_q;
            default:     rd_val = '0;
        endcase
    end

    // Edge events are qualified only by the enables, not by MODE.
    assign isr_set = (pin_rise & rise_en_q) | (pin_fall & fall_en_q);
    assign isr_clr = (wr_commit && (sel == SEL_ISR)) ? wdata : '0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            mode_q    <= '0;
            odr_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            isr_q     <= '0;
        end else begin
            if (wr_commit) begin
                case (sel)
                    SEL_MODE:    mode_q    <= wdata;
                    SEL_ODR:     odr_q     <= wdata;
                    SEL_RISE_EN: rise_en_q <= wdata;
                    SEL_FALL_EN: fall_en_q <= wdata;
                    default:     ;
                endcase
            end
            // A new event in the clearing cycle survives the clear.
            isr_q <= (isr_q & ~isr_clr) | isr_set;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            PREADY  <= first_acc;
            PSLVERR <= first_acc & ~mapped;
            // Writes leave PRDATA alone; unmapped accesses return zero.
            if (rd_load) begin
                PRDATA <= mapped ? 32'(rd_val) : 32'd0;
            end
        end
    end

    assign gpio_out = odr_q;
    assign gpio_oe  = mode_q;
    assign irq      = |isr_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// -----------------------------------------------------------------------------
// tb_apb_gpio_irq
// Self-checking bench for apb_gpio_irq (WIDTH = 8, SYNC_STAGES = 2).
// A table of APB transfers is applied in a loop; each transfer pushes its
// expected response to a scoreboard queue which is popped when PREADY rises.
// Hand-written sequences cover interrupt timing, W1C/set collision, aborted
// transfers and reset during an access.
// -----------------------------------------------------------------------------
module tb_apb_gpio_irq;

    logic        PCLK;
    logic        PRESET;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;

    apb_gpio_irq #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0]  gin;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    typedef struct {
        string       name;
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // One zero-wait APB transfer; the expected response goes through the queue.
    task automatic xfer(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                        input string nm, input logic chk_rd, input logic [31:0] exp_rd,
                        input logic exp_err);
        exp_t e;
        int   n;
        e.name   = nm;
        e.chk_rd = chk_rd;
        e.rd     = exp_rd;
        e.err    = exp_err;
        sb.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(posedge PCLK); #1;
            n++;
        end while (!PREADY && n < 8);
        PSEL = 1'b0; PENABLE = 1'b0;
        e = sb.pop_front();
        if (!PREADY) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: PREADY never rose within %0d cycles", e.name, n);
        end else begin
            chk({e.name, "_lat"}, 32'(n), 32'd1);
            chk({e.name, "_err"}, {31'd0, PSLVERR}, {31'd0, e.err});
            if (e.chk_rd) chk({e.name, "_rd"}, PRDATA, e.rd);
        end
        // PREADY is a single-cycle pulse.
        @(posedge PCLK); #1;
        chk({e.name, "_rdy_low"}, {31'd0, PREADY}, 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        // gin, wr, addr, wdata, chk_rd, rdata, err
        vecs[0]  = '{8'h00, 1'b0, 5'h00, 32'h0,  1'b1, 32'h00, 1'b0};
        vecs[1]  = '{8'h00, 1'b0, 5'h04, 32'h0,  1'b1, 32'h00, 1'b0};
        vecs[2]  = '{8'h00, 1'b0, 5'h08, 32'h0,  1'b1, 32'h00, 1'b0};
        vecs[3]  = '{8'h00, 1'b0, 5'h0C, 32'h0,  1'b1, 32'h00, 1'b0};
        vecs[4]  = '{8'h00, 1'b0, 5'h10, 32'h0,  1'b1, 32'h00, 1'b0};
        vecs[5]  = '{8'h00, 1'b0, 5'h14, 32'h0,  1'b1, 32'h00, 1'b0};
        vecs[6]  = '{8'h30, 1'b1, 5'h00, 32'hFFFFFF0F, 1'b0, 32'h00, 1'b0};
        vecs[7]  = '{8'h30, 1'b1, 5'h04, 32'h000000A5, 1'b0, 32'h00, 1'b0};
        vecs[8]  = '{8'h30, 1'b0, 5'h00, 32'h0,  1'b1, 32'h0F, 1'b0};
        vecs[9]  = '{8'h30, 1'b0, 5'h05, 32'h0,  1'b1, 32'hA5, 1'b0};
        vecs[10] = '{8'h30, 1'b0, 5'h08, 32'h0,  1'b1, 32'h35, 1'b0};
        vecs[11] = '{8'h30, 1'b0, 5'h18, 32'h0,  1'b1, 32'h00, 1'b1};
        vecs[12] = '{8'h30, 1'b1, 5'h1C, 32'hFF, 1'b0, 32'h00, 1'b1};
        vecs[13] = '{8'h30, 1'b0, 5'h00, 32'h0,  1'b1, 32'h0F, 1'b0};
        vecs[14] = '{8'h30, 1'b0, 5'h04, 32'h0,  1'b1, 32'hA5, 1'b0};
        vecs[15] = '{8'h30, 1'b0, 5'h0C, 32'h0,  1'b1, 32'h00, 1'b0};
        vecs[16] = '{8'h30, 1'b0, 5'h10, 32'h0,  1'b1, 32'h00, 1'b0};
        vecs[17] = '{8'h30, 1'b0, 5'h14, 32'h0,  1'b1, 32'h00, 1'b0};
        vecs[18] = '{8'hB0, 1'b1, 5'h0C, 32'h01, 1'b0, 32'h00, 1'b0};
        vecs[19] = '{8'hB0, 1'b1, 5'h10, 32'h80, 1'b0, 32'h00, 1'b0};
        vecs[20] = '{8'hB0, 1'b0, 5'h0C, 32'h0,  1'b1, 32'h01, 1'b0};
        vecs[21] = '{8'hB0, 1'b0, 5'h10, 32'h0,  1'b1, 32'h80, 1'b0};
        vecs[22] = '{8'hB0, 1'b0, 5'h14, 32'h0,  1'b1, 32'h00, 1'b0};
        vecs[23] = '{8'hB0, 1'b0, 5'h08, 32'h0,  1'b1, 32'hB5, 1'b0};

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; gpio_in = 8'h00;
        wait_cycles(3);
        chk("rst_prdata",  PRDATA, 32'd0);
        chk("rst_pready",  {31'd0, PREADY}, 32'd0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("rst_oe",      {24'd0, gpio_oe}, 32'd0);
        chk("rst_out",     {24'd0, gpio_out}, 32'd0);
        chk("rst_irq",     {31'd0, irq}, 32'd0);
        PRESET = 1'b0;
        wait_cycles(2);

        for (int i = 0; i < 24; i++) begin
            gpio_in = vecs[i].gin;
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, $sformatf("vec%0d", i),
                 vecs[i].chk_rd, vecs[i].rd, vecs[i].err);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'd0);
        end
        chk("pins_oe",  {24'd0, gpio_oe},  32'h0F);
        chk("pins_out", {24'd0, gpio_out}, 32'hA5);

        // Pin 0 rises and pin 7 falls together; ISR sets two edges after capture.
        @(posedge PCLK); #1;
        gpio_in = 8'h31;
        @(posedge PCLK); #1;
        chk("edge_k_irq", {31'd0, irq}, 32'd0);
        @(posedge PCLK); #1;
        chk("edge_k1_irq", {31'd0, irq}, 32'd0);
        @(posedge PCLK); #1;
        chk("edge_k2_irq", {31'd0, irq}, 32'd1);
        xfer(1'b0, 5'h14, 32'h0, "isr_81", 1'b1, 32'h81, 1'b0);
        xfer(1'b1, 5'h14, 32'h01, "isr_w1c0", 1'b0, 32'h0, 1'b0);
        xfer(1'b0, 5'h14, 32'h0, "isr_80", 1'b1, 32'h80, 1'b0);
        chk("irq_still", {31'd0, irq}, 32'd1);
        // Disabling the enables leaves the pending bit alone.
        xfer(1'b1, 5'h10, 32'h0, "fall_dis", 1'b0, 32'h0, 1'b0);
        xfer(1'b0, 5'h14, 32'h0, "isr_kept", 1'b1, 32'h80, 1'b0);
        xfer(1'b1, 5'h14, 32'h80, "isr_w1c7", 1'b0, 32'h0, 1'b0);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        xfer(1'b0, 5'h14, 32'h0, "isr_zero", 1'b1, 32'h00, 1'b0);

        // W1C of bit 0 on the very edge a new pin-0 rise sets it.
        gpio_in = 8'h30;
        wait_cycles(4);
        @(posedge PCLK); #1;
        gpio_in = 8'h31;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h14; PWDATA = 32'h01;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        chk("coll_pready", {31'd0, PREADY}, 32'd1);
        chk("coll_irq", {31'd0, irq}, 32'd1);
        PSEL = 1'b0; PENABLE = 1'b0;
        xfer(1'b0, 5'h14, 32'h0, "coll_isr", 1'b1, 32'h01, 1'b0);

        // Transfer abandoned before the access phase: no commit, no PREADY.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h04; PWDATA = 32'h11;
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            chk($sformatf("abort_rdy%0d", i), {31'd0, PREADY}, 32'd0);
        end
        chk("abort_out", {24'd0, gpio_out}, 32'hA5);

        // Reset lands in the access phase of ODR = 0xFF.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h04; PWDATA = 32'hFF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 PRESET = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("rstx_out", {24'd0, gpio_out}, 32'h00);
        chk("rstx_rdy", {31'd0, PREADY}, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        chk("rstx_oe",  {24'd0, gpio_oe}, 32'h00);
        chk("rstx_irq", {31'd0, irq}, 32'd0);
        wait_cycles(4);
        xfer(1'b0, 5'h04, 32'h0, "rstx_odr", 1'b1, 32'h00, 1'b0);
        xfer(1'b0, 5'h14, 32'h0, "rstx_isr", 1'b1, 32'h00, 1'b0);
        xfer(1'b0, 5'h08, 32'h0, "rstx_idr", 1'b1, 32'h31, 1'b0);
        chk("rstx_irq2", {31'd0, irq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
